calc_controller: RTL and testbench

Sequencing FSM for the calculator datapath. It walks a read address range in operand memory and steers each adder result into the low or high half of the 64-bit result buffer via `loc_sel_o`. Each filled buffer word is written back to a write address range. It sits between the top-level start/config registers and the SRAM, adder and `result_buffer` instances.

---
 rtl/calc_controller.sv | 143 ++++++++++++++
 tb/tb_calc_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// Sequencing FSM for the calculator datapath: reads operand pairs, steers sums into buffer halves, writes results back.
// Optional performance counters are enabled by defining CALC_CTRL_PERF_EN.
module calc_controller #(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    input  logic [ADDR_W-1:0] write_end_addr_i,
    output logic              read_en_o,
    output logic [ADDR_W-1:0] read_addr_o,
    output logic              write_en_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic              loc_sel_o,
    output logic              busy_o,
    output logic              done_o
`ifdef CALC_CTRL_PERF_EN
    ,
    output logic [31:0]       busy_cycles_o,
    output logic [ADDR_W:0]   add_count_o
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_end_q, r_end_d;
    logic [ADDR_W-1:0] w_end_q, w_end_d;
    logic              loc_sel_q, loc_sel_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        r_ptr_d   = r_ptr_q;
        w_ptr_d   = w_ptr_q;
        r_end_d   = r_end_q;
        w_end_d   = w_end_q;
        loc_sel_d = loc_sel_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    r_ptr_d   = read_start_addr_i;
                    w_ptr_d   = write_start_addr_i;
                    r_end_d   = read_end_addr_i;
                    w_end_d   = write_end_addr_i;
                    loc_sel_d = 1'b0;
                    if ((read_start_addr_i > read_end_addr_i) ||
                        (write_start_addr_i > write_end_addr_i)) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_ADD;
            S_ADD: begin
                loc_sel_d = ~loc_sel_q;
                if ((r_ptr_q == r_end_q) || loc_sel_q) begin
                    state_d = S_WRITE;
                end else begin
                    r_ptr_d = r_ptr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                // Clearing on every exit keeps the high half untouched while idle.
                loc_sel_d = 1'b0;
                if ((r_ptr_q == r_end_q) || (w_ptr_q == w_end_q)) begin
                    state_d = S_END;
                end else begin
                    r_ptr_d = r_ptr_q + 1'b1;
                    w_ptr_d = w_ptr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            r_ptr_q   <= '0;
            w_ptr_q   <= '0;
            r_end_q   <= '0;
            w_end_q   <= '0;
            loc_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_ptr_q   <= r_ptr_d;
            w_ptr_q   <= w_ptr_d;
            r_end_q   <= r_end_d;
            w_end_q   <= w_end_d;
            loc_sel_q <= loc_sel_d;
        end
    end

    assign read_en_o    = (state_q == S_READ);
    assign read_addr_o  = r_ptr_q;
    assign write_en_o   = (state_q == S_WRITE);
    assign write_addr_o = w_ptr_q;
    assign loc_sel_o    = loc_sel_q;
    assign busy_o       = (state_q == S_READ) || (state_q == S_ADD) || (state_q == S_WRITE);
    assign done_o       = (state_q == S_END);

`ifdef CALC_CTRL_PERF_EN
    logic [31:0]     busy_cycles_q;
    logic [ADDR_W:0] add_count_q;
    logic            start_acc;

    assign start_acc = (state_q == S_IDLE) && start_i;

    // Saturating counters; they hold after END until the next accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            busy_cycles_q <= '0;
            add_count_q   <= '0;
        end else begin
            if (busy_o && (busy_cycles_q != '1)) begin
                busy_cycles_q <= busy_cycles_q + 1'b1;
            end
            if ((state_q == S_ADD) && (add_count_q != '1)) begin
                add_count_q <= add_count_q + 1'b1;
            end
        end
    end

    assign busy_cycles_o = busy_cycles_q;
    assign add_count_o   = add_count_q;
`endif

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: a transaction-level model predicts reads, writes and done,
// and a negedge monitor with a simple SRAM/adder/buffer model compares what the DUT does.
module tb_calc_controller;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int NO_ABORT = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] rs_i = '0, re_i = '0, ws_i = '0, we_i = '0;
    logic              read_en_o, write_en_o, loc_sel_o, busy_o, done_o;
    logic [ADDR_W-1:0] read_addr_o, write_addr_o;
`ifdef CALC_CTRL_PERF_EN
    logic [31:0]       busy_cycles_o;
    logic [ADDR_W:0]   add_count_o;
`endif

    calc_controller #(.ADDR_W(ADDR_W)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .read_start_addr_i  (rs_i),
        .read_end_addr_i    (re_i),
        .write_start_addr_i (ws_i),
        .write_end_addr_i   (we_i),
        .read_en_o          (read_en_o),
        .read_addr_o        (read_addr_o),
        .write_en_o         (write_en_o),
        .write_addr_o       (write_addr_o),
        .loc_sel_o          (loc_sel_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
`ifdef CALC_CTRL_PERF_EN
        ,
        .busy_cycles_o      (busy_cycles_o),
        .add_count_o        (add_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          addr;
        logic [63:0] data;
        int          cyc;
        int          loc;
        int          busy_cnt;
        int          add_cnt;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [31:0] hi_prev = '0;
    logic [63:0] buf_m = '0;
    logic [31:0] dout_m = '0;
    logic [63:0] sram_w [int];
    int          rel = 0;

    function automatic logic [31:0] sum_at(input int a);
        return a_mem[a] + b_mem[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int addr, input logic [63:0] data, input int cyc,
                           input int loc, input int bc, input int ac, input int abort_cyc);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = cyc;
        e.loc = loc; e.busy_cnt = bc; e.add_cnt = ac;
        if (cyc <= abort_cyc) exp_q.push_back(e);
    endtask

    // Transaction-level reference: operands are consumed two per result word, one READ+ADD
    // pair of cycles each, followed by one WRITE; an odd tail keeps the last high half.
    task automatic predict(input int rs, input int re, input int ws, input int we, input int abort_cyc);
        int cyc, nreads, n_ops, n_w, n_writes, base, ops;
        logic [31:0] lo, hi;
        cyc = 0; nreads = 0;
        if (rs > re || ws > we) begin
            push_ev(K_DONE, 0, '0, 1, 0, 0, 0, abort_cyc);
            return;
        end
        n_ops    = re - rs + 1;
        n_w      = we - ws + 1;
        n_writes = (n_ops + 1) / 2;
        if (n_w < n_writes) n_writes = n_w;
        for (int w = 0; w < n_writes; w++) begin
            base = rs + 2 * w;
            ops  = (n_ops - 2 * w >= 2) ? 2 : 1;
            for (int k = 0; k < ops; k++) begin
                cyc++;
                push_ev(K_READ, base + k, '0, cyc, k, 0, 0, abort_cyc);
                nreads++;
                cyc++;
            end
            lo = sum_at(base);
            hi = (ops == 2) ? sum_at(base + 1) : hi_prev;
            hi_prev = hi;
            cyc++;
            push_ev(K_WRITE, ws + w, {hi, lo}, cyc, 0, 0, 0, abort_cyc);
        end
        cyc++;
        push_ev(K_DONE, 0, '0, cyc, 0, cyc - 1, nreads, abort_cyc);
    endtask

    // Monitor plus datapath environment: SRAM data one cycle after a read (random otherwise),
    // buffer half loc_sel captured every cycle, SRAM write samples the buffer before that capture.
    always @(negedge clk) begin
        ev_t e;
        int  kind_act;
        rel++;
        if (read_en_o === 1'b1 || write_en_o === 1'b1 || done_o === 1'b1) begin
            kind_act = (read_en_o === 1'b1) ? K_READ : (write_en_o === 1'b1) ? K_WRITE : K_DONE;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind_act, rel);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 64'(kind_act), 64'(e.kind));
                check("event_cycle", 64'(rel), 64'(e.cyc));
                if (e.kind == K_READ) begin
                    check("read_addr", 64'(read_addr_o), 64'(e.addr));
                    check("read_loc_sel", 64'(loc_sel_o), 64'(e.loc));
                    check("read_busy", 64'(busy_o), 64'd1);
                end else if (e.kind == K_WRITE) begin
                    check("write_addr", 64'(write_addr_o), 64'(e.addr));
                    check("write_data", buf_m, e.data);
                    check("write_busy", 64'(busy_o), 64'd1);
                end else begin
                    check("done_busy", 64'(busy_o), 64'd0);
`ifdef CALC_CTRL_PERF_EN
                    check("perf_busy_cycles", 64'(busy_cycles_o), 64'(e.busy_cnt));
                    check("perf_add_count", 64'(add_count_o), 64'(e.add_cnt));
`endif
                end
            end
        end
        if (write_en_o === 1'b1) sram_w[int'(write_addr_o)] = buf_m;
        if (loc_sel_o === 1'b1) buf_m[63:32] = dout_m;
        else                    buf_m[31:0]  = dout_m;
        dout_m = (read_en_o === 1'b1) ? sum_at(int'(read_addr_o)) : $urandom;
        if (rst_i) buf_m = '0;
        if (start_i) rel = 0;
    end

    task automatic check_idle(input string tag);
        check({tag, "_read_en"},    64'(read_en_o),    64'd0);
        check({tag, "_write_en"},   64'(write_en_o),   64'd0);
        check({tag, "_loc_sel"},    64'(loc_sel_o),    64'd0);
        check({tag, "_busy"},       64'(busy_o),       64'd0);
        check({tag, "_done"},       64'(done_o),       64'd0);
        check({tag, "_read_addr"},  64'(read_addr_o),  64'd0);
        check({tag, "_write_addr"}, 64'(write_addr_o), 64'd0);
    endtask

    task automatic run(input int rs, input int re, input int ws, input int we, input int abort_cyc);
        predict(rs, re, ws, we, abort_cyc);
        @(posedge clk);
        #1;
        rs_i = ADDR_W'(rs); re_i = ADDR_W'(re); ws_i = ADDR_W'(ws); we_i = ADDR_W'(we);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        rs_i = ADDR_W'($urandom); re_i = ADDR_W'($urandom);
        ws_i = ADDR_W'($urandom); we_i = ADDR_W'($urandom);
        if (abort_cyc != NO_ABORT) begin
            repeat (abort_cyc - 1) @(posedge clk);
            #1;
            rst_i = 1'b1;
            @(posedge clk);
            #1;
            rst_i = 1'b0;
            hi_prev = '0;
            @(negedge clk);
            check_idle("abort");
        end
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rs, re, ws, we;
        for (int i = 0; i < DEPTH; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        a_mem[0] = 32'd5;  b_mem[0] = 32'd7;
        a_mem[1] = 32'd10; b_mem[1] = 32'd20;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("reset");

        run(0, 3, 100, 101, NO_ABORT);
        check("sram100_pair", sram_w[100], 64'h0000001E_0000000C);
        run(0, 2, 100, 101, NO_ABORT);
        run(0, 7, 100, 100, NO_ABORT);
        run(5, 4, 0, 10, NO_ABORT);
        run(0, 3, 20, 10, NO_ABORT);
        run(510, 511, 511, 511, NO_ABORT);
        run(0, 3, 100, 101, 4);
        run(0, 0, 200, 200, NO_ABORT);
        check("sram200_single_after_reset", sram_w[200], 64'h00000000_0000000C);
        run(0, 3, 100, 101, NO_ABORT);

        for (int n = 0; n < 40; n++) begin
            rs = $urandom_range(0, 500);
            re = rs + $urandom_range(0, 9);
            if (re > DEPTH - 1) re = DEPTH - 1;
            if ($urandom_range(0, 9) == 0 && rs > 0) re = rs - 1;
            ws = $urandom_range(0, 505);
            we = ws + $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0 && ws > 0) we = ws - 1;
            run(rs, re, ws, we, NO_ABORT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
